// File: rtl/alu_pkg.sv
// alu_pkg: command codes, FSM states and operand-conditioning helpers shared by the ALU family.
package alu_pkg;
    localparam logic [2:0] CMD_ADD  = 3'b000;
    localparam logic [2:0] CMD_SUB  = 3'b001;
    localparam logic [2:0] CMD_XOR  = 3'b010;
    localparam logic [2:0] CMD_SLT  = 3'b011;
    localparam logic [2:0] CMD_AND  = 3'b100;
    localparam logic [2:0] CMD_NAND = 3'b101;
    localparam logic [2:0] CMD_NOR  = 3'b110;
    localparam logic [2:0] CMD_OR   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Subtraction-style commands run as A + ~B + 1.
    function automatic logic inv_b(input logic [2:0] cmd);
        return cmd == CMD_SUB || cmd == CMD_SLT;
    endfunction

    function automatic logic is_arith(input logic [2:0] cmd);
        return cmd == CMD_ADD || cmd == CMD_SUB;
    endfunction
endpackage

// File: rtl/alu_chunk.sv
// alu_chunk: combinational CHUNK-bit ALU slice; b arrives pre-inverted for SUB/SLT.
module alu_chunk
    import alu_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    input  logic [2:0]       cmd,
    output logic [CHUNK-1:0] y,
    output logic             cout,
    output logic             c_into_msb
);
    logic [CHUNK:0] w_sum;

    assign w_sum      = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign cout       = w_sum[CHUNK];
    // Carry into the top bit recovered from that bit's sum and inputs.
    assign c_into_msb = w_sum[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
    assign y = cmd == CMD_XOR  ? a ^ b :
               cmd == CMD_AND  ? a & b :
               cmd == CMD_NAND ? ~(a & b) :
               cmd == CMD_NOR  ? ~(a | b) :
               cmd == CMD_OR   ? a | b :
                                 w_sum[CHUNK-1:0];
endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: sequential ALU computing CHUNK bits per clock, LSB chunk first,
// with valid/ready handshakes on operand and result sides.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic [2:0]       command,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             zero,
    output logic             overflow
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = NCHUNK > 1 ? $clog2(NCHUNK) : 1;

    state_t           r_state;
    logic [WIDTH-1:0] r_a, r_b, r_acc, r_res;
    logic [2:0]       r_cmd;
    logic [IW-1:0]    r_idx;
    logic             r_carry, r_cout, r_zero, r_ovf, r_in_ready, r_out_valid;

    logic [CHUNK-1:0] w_y;
    logic             w_cout, w_cmsb, w_last, w_arith, w_slt;
    logic [WIDTH-1:0] w_full, w_final;

    alu_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a          (r_a[r_idx*CHUNK +: CHUNK]),
        .b          (r_b[r_idx*CHUNK +: CHUNK]),
        .cin        (r_carry),
        .cmd        (r_cmd),
        .y          (w_y),
        .cout       (w_cout),
        .c_into_msb (w_cmsb)
    );

    assign w_last  = r_idx == IW'(NCHUNK - 1);
    assign w_arith = is_arith(r_cmd);
    assign w_slt   = w_y[CHUNK-1] ^ w_cmsb ^ w_cout;

    // Working result with the current slice merged, so finalise sees all bits.
    always_comb begin
        w_full = r_acc;
        w_full[r_idx*CHUNK +: CHUNK] = w_y;
    end

    assign w_final = r_cmd == CMD_SLT ? {{(WIDTH-1){1'b0}}, w_slt} : w_full;

    // Results land in r_res only at finalise, so a partial sum never reaches the outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_res       <= '0;
            r_cmd       <= CMD_ADD;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (in_valid) begin
                    r_a        <= operandA;
                    r_b        <= inv_b(command) ? ~operandB : operandB;
                    r_cmd      <= command;
                    r_carry    <= inv_b(command);
                    r_idx      <= '0;
                    r_in_ready <= 1'b0;
                    r_state    <= ST_RUN;
                end
                ST_RUN: begin
                    r_acc   <= w_full;
                    r_carry <= w_cout;
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        r_res       <= w_final;
                        r_cout      <= w_arith & w_cout;
                        r_ovf       <= w_arith & (w_cmsb ^ w_cout);
                        r_zero      <= w_final == '0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_res;
    assign carryout  = r_cout;
    assign zero      = r_zero;
    assign overflow  = r_ovf;
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: scoreboard bench for alu_multicycle (32/8 instance plus an 8/8 instance).
module tb_alu_multicycle;
    typedef struct {
        logic [31:0] res;
        logic        c, z, o;
        int          acc;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] opa, opb, result;
    logic [2:0]  cmd;
    logic        carryout, zero, overflow;

    logic       v8, rdy8, ov8, c8o, z8, o8;
    logic [7:0] a8, b8, res8;
    logic [2:0] cmd8;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   seen = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    alu_multicycle #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .operandA(opa), .operandB(opb), .command(cmd),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .carryout(carryout), .zero(zero), .overflow(overflow)
    );

    alu_multicycle #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(v8), .in_ready(rdy8),
        .operandA(a8), .operandB(b8), .command(cmd8),
        .out_valid(ov8), .out_ready(1'b1), .result(res8),
        .carryout(c8o), .zero(z8), .overflow(o8)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t ex(input string nm, input logic [31:0] r, input logic c, input logic z, input logic o);
        exp_t e;
        e.name = nm; e.res = r; e.c = c; e.z = z; e.o = o; e.acc = 0;
        return e;
    endfunction

    // Behavioural reference: wide add/sub, signed compare, plain logic ops.
    function automatic exp_t model(input string nm, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        exp_t e;
        logic [32:0] s;
        e = ex(nm, 32'h0, 1'b0, 1'b0, 1'b0);
        case (c)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                e.res = s[31:0]; e.c = s[32];
                e.o = (a[31] == b[31]) && (e.res[31] != a[31]);
            end
            3'd1: begin
                s = {1'b0, a} - {1'b0, b};
                e.res = s[31:0]; e.c = (a >= b);
                e.o = (a[31] != b[31]) && (e.res[31] != a[31]);
            end
            3'd2: e.res = a ^ b;
            3'd3: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4: e.res = a & b;
            3'd5: e.res = ~(a & b);
            3'd6: e.res = ~(a | b);
            default: e.res = a | b;
        endcase
        e.z = e.res == 32'h0;
        return e;
    endfunction

    // Monitor: compares every cycle the DUT presents a result, pops on handshake.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got result %h expected no output", result);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    chk({sb[0].name, "_latency"}, cyc - sb[0].acc, 32'd4);
                end
                chk({sb[0].name, "_result"}, result, sb[0].res);
                chk({sb[0].name, "_carryout"}, carryout, sb[0].c);
                chk({sb[0].name, "_zero"}, zero, sb[0].z);
                chk({sb[0].name, "_overflow"}, overflow, sb[0].o);
                chk({sb[0].name, "_in_ready_busy"}, in_ready, 1'b0);
                if (out_ready) begin
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c, input exp_t e);
        int n = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1; opa = a; opb = b; cmd = c;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({e.name, "_accept"}, in_ready, 1'b1);
        @(posedge clk);
        #1;
        e.acc = cyc;
        sb.push_back(e);
        in_valid = 1'b0;
        opa = $urandom; opb = $urandom; cmd = 3'($urandom_range(0, 7));
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_drain"}, sb.size(), 32'd0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        opa = '0; opb = '0; cmd = '0;
        v8 = 1'b0; a8 = '0; b8 = '0; cmd8 = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", result, 32'h0);
        chk("rst_flags", {carryout, zero, overflow}, 3'b000);
        chk("rst8_in_ready", rdy8, 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;

        send(32'h7FFF_FFFF, 32'h0000_0001, 3'd0, ex("add_ovf", 32'h8000_0000, 1'b0, 1'b0, 1'b1));
        drain("add_ovf");
        send(32'h1, 32'h1, 3'd1, ex("sub_zero", 32'h0, 1'b1, 1'b1, 1'b0));
        drain("sub_zero");
        send(32'hFFFF_FFFF, 32'h1, 3'd3, ex("slt_neg", 32'h1, 1'b0, 1'b0, 1'b0));
        send(32'h1, 32'h1, 3'd3, ex("slt_eq", 32'h0, 1'b0, 1'b1, 1'b0));
        drain("slt");

        // Backpressure: result held for 10 cycles, a competing offer must be ignored.
        out_ready = 1'b0;
        send(32'h1234_5678, 32'hFFFF_0000, 3'd2, ex("xor_bp", 32'hEDCB_5678, 1'b0, 1'b0, 1'b0));
        for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
        chk("bp_out_valid", out_valid, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b1; opa = 32'h5; opb = 32'h6; cmd = 3'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_in_ready_low", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_back", in_ready, 1'b1);
        chk("bp_out_valid_low", out_valid, 1'b0);
        drain("xor_bp");

        // Async reset with the op at idx 2 drops it.
        send(32'hF0F0_F0F0, 32'hFF00_FF00, 3'd4, ex("and_dropped", 32'hF000_F000, 1'b0, 1'b0, 1'b0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_result", result, 32'h0);
        sb.delete();
        seen = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;

        send(32'hF0F0_F0F0, 32'hFF00_FF00, 3'd5, ex("nand", 32'h0FFF_0FFF, 1'b0, 1'b0, 1'b0));
        drain("nand");

        // 8-bit single-chunk instance: one-edge latency.
        @(posedge clk);
        #1;
        v8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; cmd8 = 3'd0;
        @(negedge clk);
        chk("w8_in_ready", rdy8, 1'b1);
        @(posedge clk);
        #1 v8 = 1'b0;
        @(negedge clk);
        chk("w8_not_yet_valid", ov8, 1'b0);
        @(negedge clk);
        chk("w8_out_valid", ov8, 1'b1);
        chk("w8_result", res8, 8'h00);
        chk("w8_flags", {c8o, z8, o8}, 3'b110);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb;
            logic [2:0] rc;
            ra = $urandom; rb = $urandom; rc = 3'(i % 8);
            if (i % 5 == 0) rb = ra;
            send(ra, rb, rc, model($sformatf("rnd%0d", i), ra, rb, rc));
        end
        drain("rnd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
